// File: rtl/shared_ram_arbiter_if.sv
// shared_ram_arbiter_if
//   Request/return bus between the shader-core load/store units and the
//   shared data RAM arbiter. One bundle carries all NUM_PORTS requesters.
//
//   req            : per-port request, held with its fields until granted
//   req_write      : per-port 1=store, 0=load
//   req_address    : per-port byte address, port i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   req_write_data : per-port store data, port i at [i*WORD_WIDTH +: WORD_WIDTH]
//   grant          : one-hot or zero, port i accepted at this clock edge
//   read_valid     : one-hot or zero, read_data belongs to port i this cycle
//   read_data      : shared read return bus
//
//   master : requester side (cores)
//   slave  : arbiter side
interface shared_ram_arbiter_if #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int WORD_WIDTH    = 32
);
  logic [NUM_PORTS-1:0]               req;
  logic [NUM_PORTS-1:0]               req_write;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_PORTS*WORD_WIDTH-1:0]    req_write_data;
  logic [NUM_PORTS-1:0]               grant;
  logic [NUM_PORTS-1:0]               read_valid;
  logic [WORD_WIDTH-1:0]              read_data;

  modport master (
    output req, req_write, req_address, req_write_data,
    input  grant, read_valid, read_data
  );

  modport slave (
    input  req, req_write, req_address, req_write_data,
    output grant, read_valid, read_data
  );
endinterface

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
//   Shares one single-port BlockRam (1-cycle registered read) between
//   NUM_PORTS core load/store requesters and a host loader port.
//   Cores are served round-robin; the chosen command is registered towards
//   the RAM, and load data comes back two cycles after the grant with a
//   one-hot read_valid strobe identifying the owner.
//
//   clock, reset_n  : system clock, synchronous active-low reset
//   core_bus        : requester bundle (slave side), see shared_ram_arbiter_if
//   ext_enable      : host owns the RAM; core grants suppressed
//   ext_write       : host write strobe
//   ext_address     : host byte address
//   ext_write_data  : host write data
//   ram_address     : word address to BlockRam
//   ram_write       : BlockRam write enable
//   ram_write_data  : BlockRam write data
//   ram_read_data   : BlockRam read data (passed straight to read_data)
module shared_ram_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  shared_ram_arbiter_if.slave      core_bus,
  input  logic                     ext_enable,
  input  logic                     ext_write,
  input  logic [ADDRESS_WIDTH-1:0] ext_address,
  input  logic [WORD_WIDTH-1:0]    ext_write_data,
  output logic [ADDRESS_WIDTH-3:0] ram_address,
  output logic                     ram_write,
  output logic [WORD_WIDTH-1:0]    ram_write_data,
  input  logic [WORD_WIDTH-1:0]    ram_read_data
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // Pointer resets to the last port so port 0 is scanned first.
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

  logic [PORT_W-1:0]        last_grant_q, last_grant_d;
  logic [ADDRESS_WIDTH-3:0] ram_address_q, ram_address_d;
  logic                     ram_write_q, ram_write_d;
  logic [WORD_WIDTH-1:0]    ram_write_data_q, ram_write_data_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [PORT_W-1:0]        s1_port_q, s1_port_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [PORT_W-1:0]        s2_port_q, s2_port_d;

  logic [NUM_PORTS-1:0]     grant_c;
  logic                     grant_found;
  logic [PORT_W-1:0]        grant_idx;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [WORD_WIDTH-1:0]    sel_data;
  logic                     unused_addr_bits;

  // Round-robin scan starting just after the last granted port, wrapping
  // modulo NUM_PORTS. The first requester found wins.
  always_comb begin : rr_scan
    int cand;
    cand        = 0;
    grant_c     = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    if (reset_n && !ext_enable) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = int'(last_grant_q) + k;
        if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
        if (!grant_found && core_bus.req[cand[PORT_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[PORT_W-1:0];
        end
      end
      if (grant_found) grant_c[grant_idx] = 1'b1;
    end
  end

  // Next RAM command and read pipeline. The host path takes priority over
  // cores; reads already in flight keep advancing regardless of who owns
  // the RAM this cycle.
  always_comb begin
    last_grant_d     = last_grant_q;
    ram_address_d    = ram_address_q;
    ram_write_d      = 1'b0;
    ram_write_data_d = ram_write_data_q;
    s1_valid_d       = 1'b0;
    s1_port_d        = s1_port_q;
    s2_valid_d       = s1_valid_q;
    s2_port_d        = s1_port_q;
    sel_address      = core_bus.req_address[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    sel_data         = core_bus.req_write_data[grant_idx*WORD_WIDTH +: WORD_WIDTH];

    if (ext_enable) begin
      ram_address_d    = ext_address[ADDRESS_WIDTH-1:2];
      ram_write_d      = ext_write;
      ram_write_data_d = ext_write_data;
    end else if (grant_found) begin
      last_grant_d     = grant_idx;
      ram_address_d    = sel_address[ADDRESS_WIDTH-1:2];
      ram_write_d      = core_bus.req_write[grant_idx];
      ram_write_data_d = sel_data;
      // Only loads travel down the return pipeline.
      s1_valid_d       = !core_bus.req_write[grant_idx];
      s1_port_d        = grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_q     <= LAST_PORT;
      ram_address_q    <= '0;
      ram_write_q      <= 1'b0;
      ram_write_data_q <= '0;
      s1_valid_q       <= 1'b0;
      s1_port_q        <= '0;
      s2_valid_q       <= 1'b0;
      s2_port_q        <= '0;
    end else begin
      last_grant_q     <= last_grant_d;
      ram_address_q    <= ram_address_d;
      ram_write_q      <= ram_write_d;
      ram_write_data_q <= ram_write_data_d;
      s1_valid_q       <= s1_valid_d;
      s1_port_q        <= s1_port_d;
      s2_valid_q       <= s2_valid_d;
      s2_port_q        <= s2_port_d;
    end
  end

  // Byte-offset bits are irrelevant to a word-addressed RAM.
  assign unused_addr_bits = ^{sel_address[1:0], ext_address[1:0]};

  // Outputs are forced idle for the whole reset cycle, not only after the
  // first reset edge, so the RAM never sees a stale write during reset.
  assign core_bus.grant      = grant_c;
  assign core_bus.read_valid = (reset_n && s2_valid_q) ? (NUM_PORTS'(1) << s2_port_q) : '0;
  assign core_bus.read_data  = ram_read_data;
  assign ram_address         = reset_n ? ram_address_q : '0;
  assign ram_write           = reset_n & ram_write_q;
  assign ram_write_data      = reset_n ? ram_write_data_q : '0;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// tb_shared_ram_arbiter
//   Self-checking bench for shared_ram_arbiter: a behavioural BlockRam,
//   directed scenarios and a randomized run against a queue-based model.
module tb_shared_ram_arbiter;
  localparam int NP = 4;
  localparam int AW = 16;
  localparam int WW = 32;

  logic          clock;
  logic          reset_n;
  logic          ext_enable;
  logic          ext_write;
  logic [AW-1:0] ext_address;
  logic [WW-1:0] ext_write_data;
  logic [AW-3:0] ram_address;
  logic          ram_write;
  logic [WW-1:0] ram_write_data;
  logic [WW-1:0] ram_read_data;
  logic [WW-1:0] mem [0:(1<<(AW-2))-1];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    int          port;
    logic [WW-1:0] data;
  } exp_t;

  shared_ram_arbiter_if #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) core_if ();

  shared_ram_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .core_bus       (core_if),
    .ext_enable     (ext_enable),
    .ext_write      (ext_write),
    .ext_address    (ext_address),
    .ext_write_data (ext_write_data),
    .ram_address    (ram_address),
    .ram_write      (ram_write),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data)
  );

  // Single-port BlockRam with registered read (old data on same-address write).
  always @(posedge clock) begin
    if (ram_write) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    core_if.req            = '0;
    core_if.req_write      = '0;
    core_if.req_address    = '0;
    core_if.req_write_data = '0;
    ext_enable             = 1'b0;
    ext_write              = 1'b0;
    ext_address            = '0;
    ext_write_data         = '0;
  endtask

  task automatic drive_req(input int p, input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d);
    core_if.req[p]                    = 1'b1;
    core_if.req_write[p]              = w;
    core_if.req_address[p*AW +: AW]   = a;
    core_if.req_write_data[p*WW +: WW] = d;
  endtask

  task automatic drop_req(input int p);
    core_if.req[p] = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
    ext_enable     = 1'b1;
    ext_write      = 1'b1;
    ext_address    = a;
    ext_write_data = d;
    tick();
    ext_enable = 1'b0;
    ext_write  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    core_if.req = '1;
    tick();
    tick();
    #1;
    checks++;
    if (core_if.grant !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant: got %b want 0000", core_if.grant); end
    checks++;
    if (core_if.read_valid !== 4'b0000) begin failures++; $display("[TB] FAIL reset_read_valid: got %b want 0000", core_if.read_valid); end
    checks++;
    if (ram_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_ram_write: got %b want 0", ram_write); end
    checks++;
    if (ram_address !== 14'h0) begin failures++; $display("[TB] FAIL reset_ram_address: got %h want 0", ram_address); end
    checks++;
    if (ram_write_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_ram_write_data: got %h want 0", ram_write_data); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (core_if.grant !== 4'b0001) begin failures++; $display("[TB] FAIL reset_first_priority: got %b want 0001", core_if.grant); end
    clear_inputs();
    tick();
  endtask

  task automatic test_single_load();
    do_reset();
    host_write(16'h0010, 32'hDEADBEEF);
    drive_req(2, 1'b0, 16'h0010, 32'h0);
    #1;
    checks++;
    if (core_if.grant !== 4'b0100) begin failures++; $display("[TB] FAIL load_grant: got %b want 0100", core_if.grant); end
    tick();
    drop_req(2);
    #1;
    checks++;
    if (ram_address !== 14'd4) begin failures++; $display("[TB] FAIL load_ram_address: got %h want 4", ram_address); end
    checks++;
    if (ram_write !== 1'b0) begin failures++; $display("[TB] FAIL load_ram_write: got %b want 0", ram_write); end
    checks++;
    if (core_if.read_valid !== 4'b0000) begin failures++; $display("[TB] FAIL load_early_valid: got %b want 0000", core_if.read_valid); end
    tick();
    #1;
    checks++;
    if (core_if.read_valid !== 4'b0100) begin failures++; $display("[TB] FAIL load_read_valid: got %b want 0100", core_if.read_valid); end
    checks++;
    if (core_if.read_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL load_read_data: got %h want deadbeef", core_if.read_data); end
    tick();
    #1;
    checks++;
    if (core_if.read_valid !== 4'b0000) begin failures++; $display("[TB] FAIL load_valid_one_cycle: got %b want 0000", core_if.read_valid); end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] exp_g;
    logic [NP-1:0] exp_rv;
    do_reset();
    for (int p = 0; p < NP; p++) host_write(AW'(p*4), 32'hA000_0000 + WW'(p));
    for (int p = 0; p < NP; p++) drive_req(p, 1'b0, AW'(p*4), 32'h0);
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g  = 4'(1) << (c % NP);
      exp_rv = (c >= 2) ? (4'(1) << ((c - 2) % NP)) : 4'b0000;
      checks++;
      if (core_if.grant !== exp_g) begin failures++; $display("[TB] FAIL rr_grant c=%0d: got %b want %b", c, core_if.grant, exp_g); end
      checks++;
      if (core_if.read_valid !== exp_rv) begin failures++; $display("[TB] FAIL rr_read_valid c=%0d: got %b want %b", c, core_if.read_valid, exp_rv); end
      if (c >= 2) begin
        checks++;
        if (core_if.read_data !== 32'hA000_0000 + WW'((c - 2) % NP)) begin
          failures++;
          $display("[TB] FAIL rr_read_data c=%0d: got %h want %h", c, core_if.read_data, 32'hA000_0000 + WW'((c - 2) % NP));
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_store_then_load();
    do_reset();
    drive_req(1, 1'b1, 16'h0020, 32'h12345678);
    drive_req(3, 1'b0, 16'h0020, 32'h0);
    #1;
    checks++;
    if (core_if.grant !== 4'b0010) begin failures++; $display("[TB] FAIL st_ld_store_grant: got %b want 0010", core_if.grant); end
    tick();
    drop_req(1);
    #1;
    checks++;
    if (core_if.grant !== 4'b1000) begin failures++; $display("[TB] FAIL st_ld_load_grant: got %b want 1000", core_if.grant); end
    checks++;
    if (ram_write !== 1'b1 || ram_address !== 14'd8 || ram_write_data !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL st_ld_store_cmd: got we=%b addr=%h data=%h want we=1 addr=8 data=12345678", ram_write, ram_address, ram_write_data);
    end
    tick();
    drop_req(3);
    #1;
    checks++;
    if (core_if.read_valid !== 4'b0000) begin failures++; $display("[TB] FAIL st_ld_store_no_valid: got %b want 0000", core_if.read_valid); end
    tick();
    #1;
    checks++;
    if (core_if.read_valid !== 4'b1000) begin failures++; $display("[TB] FAIL st_ld_read_valid: got %b want 1000", core_if.read_valid); end
    checks++;
    if (core_if.read_data !== 32'h12345678) begin failures++; $display("[TB] FAIL st_ld_read_data: got %h want 12345678", core_if.read_data); end
    tick();
  endtask

  task automatic test_host_path();
    do_reset();
    drive_req(0, 1'b0, 16'h0008, 32'h0);
    drive_req(2, 1'b0, 16'h0008, 32'h0);
    ext_enable     = 1'b1;
    ext_write      = 1'b1;
    ext_address    = 16'h0008;
    ext_write_data = 32'hCAFEF00D;
    #1;
    checks++;
    if (core_if.grant !== 4'b0000) begin failures++; $display("[TB] FAIL host_grant_blocked: got %b want 0000", core_if.grant); end
    tick();
    ext_write = 1'b0;
    #1;
    checks++;
    if (core_if.grant !== 4'b0000) begin failures++; $display("[TB] FAIL host_grant_blocked2: got %b want 0000", core_if.grant); end
    checks++;
    if (ram_address !== 14'd2 || ram_write !== 1'b1 || ram_write_data !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL host_cmd: got addr=%h we=%b data=%h want addr=2 we=1 data=cafef00d", ram_address, ram_write, ram_write_data);
    end
    tick();
    ext_enable = 1'b0;
    #1;
    checks++;
    if (core_if.grant !== 4'b0001) begin failures++; $display("[TB] FAIL host_after_port0: got %b want 0001", core_if.grant); end
    tick();
    drop_req(0);
    #1;
    checks++;
    if (core_if.grant !== 4'b0100) begin failures++; $display("[TB] FAIL host_after_port2: got %b want 0100", core_if.grant); end
    tick();
    drop_req(2);
    #1;
    checks++;
    if (core_if.read_valid !== 4'b0001 || core_if.read_data !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL host_read0: got rv=%b data=%h want rv=0001 data=cafef00d", core_if.read_valid, core_if.read_data);
    end
    tick();
    #1;
    checks++;
    if (core_if.read_valid !== 4'b0100 || core_if.read_data !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL host_read2: got rv=%b data=%h want rv=0100 data=cafef00d", core_if.read_valid, core_if.read_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    drive_req(0, 1'b0, 16'h0010, 32'h0);
    #1;
    checks++;
    if (core_if.grant !== 4'b0001) begin failures++; $display("[TB] FAIL midrst_grant: got %b want 0001", core_if.grant); end
    tick();
    drop_req(0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (core_if.read_valid !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_valid_in_reset: got %b want 0000", core_if.read_valid); end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (core_if.read_valid !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_valid c=%0d: got %b want 0000", c, core_if.read_valid); end
      tick();
    end
    drive_req(0, 1'b1, 16'h0040, 32'h1);
    drive_req(3, 1'b1, 16'h0044, 32'h2);
    #1;
    checks++;
    if (core_if.grant !== 4'b0001) begin failures++; $display("[TB] FAIL midrst_pointer: got %b want 0001", core_if.grant); end
    tick();
    clear_inputs();
  endtask

  task automatic test_rotation_continue();
    do_reset();
    drive_req(2, 1'b1, 16'h0030, 32'h5);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (core_if.grant !== 4'b0100) begin failures++; $display("[TB] FAIL rot_port2 c=%0d: got %b want 0100", c, core_if.grant); end
      tick();
    end
    drop_req(2);
    drive_req(1, 1'b1, 16'h0034, 32'h6);
    drive_req(3, 1'b1, 16'h0038, 32'h7);
    #1;
    checks++;
    if (core_if.grant !== 4'b1000) begin failures++; $display("[TB] FAIL rot_port3_first: got %b want 1000", core_if.grant); end
    tick();
    drop_req(3);
    #1;
    checks++;
    if (core_if.grant !== 4'b0010) begin failures++; $display("[TB] FAIL rot_port1_next: got %b want 0010", core_if.grant); end
    tick();
    clear_inputs();
  endtask

  // Random requesters that hold requests until granted, plus occasional host
  // cycles. The model keeps a shadow memory updated in command order and a
  // queue of expected returns keyed by the cycle they are due.
  task automatic test_random();
    logic [WW-1:0] shadow [16];
    bit            pend [NP];
    bit            pw [NP];
    logic [AW-1:0] pa [NP];
    logic [WW-1:0] pd [NP];
    int            waitc [NP];
    exp_t          q [$];
    int            last;
    int            g;
    int            cand;
    bit            ext_now;
    logic [NP-1:0] exp_g;
    logic [NP-1:0] exp_rv;
    logic [WW-1:0] exp_data;

    do_reset();
    last = NP - 1;
    for (int w = 0; w < 16; w++) begin
      shadow[w] = $urandom;
      host_write(AW'(w*4), shadow[w]);
    end
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0; pw[p] = 1'b0; pa[p] = '0; pd[p] = '0; waitc[p] = 0;
    end

    for (int cyc = 0; cyc < 503; cyc++) begin
      ext_now = 1'b0;
      if (cyc < 500) begin
        for (int p = 0; p < NP; p++) begin
          if (!pend[p] && $urandom_range(0, 1) == 1) begin
            pend[p]  = 1'b1;
            pw[p]    = ($urandom_range(0, 2) == 0);
            pa[p]    = AW'($urandom_range(0, 63));
            pd[p]    = $urandom;
            waitc[p] = 0;
          end
          core_if.req[p]                     = pend[p];
          core_if.req_write[p]               = pw[p];
          core_if.req_address[p*AW +: AW]    = pa[p];
          core_if.req_write_data[p*WW +: WW] = pd[p];
        end
        ext_now        = ($urandom_range(0, 9) == 0);
        ext_enable     = ext_now;
        ext_write      = 1'($urandom_range(0, 1));
        ext_address    = AW'($urandom_range(0, 63));
        ext_write_data = $urandom;
      end else begin
        clear_inputs();
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
      end
      #1;

      g = -1;
      if (!ext_now) begin
        for (int k = 1; k <= NP; k++) begin
          cand = (last + k) % NP;
          if (g < 0 && pend[cand]) g = cand;
        end
      end
      exp_g = (g >= 0) ? (4'(1) << g) : 4'b0000;
      checks++;
      if (core_if.grant !== exp_g) begin failures++; $display("[TB] FAIL rnd_grant cyc=%0d: got %b want %b", cyc, core_if.grant, exp_g); end

      exp_rv   = 4'b0000;
      exp_data = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rv   = 4'(1) << q[0].port;
        exp_data = q[0].data;
        void'(q.pop_front());
      end
      checks++;
      if (core_if.read_valid !== exp_rv) begin failures++; $display("[TB] FAIL rnd_read_valid cyc=%0d: got %b want %b", cyc, core_if.read_valid, exp_rv); end
      if (exp_rv != 4'b0000) begin
        checks++;
        if (core_if.read_data !== exp_data) begin failures++; $display("[TB] FAIL rnd_read_data cyc=%0d: got %h want %h", cyc, core_if.read_data, exp_data); end
      end

      if (ext_now) begin
        if (ext_write) shadow[ext_address[5:2]] = ext_write_data;
      end else if (g >= 0) begin
        checks++;
        if (waitc[g] >= NP) begin failures++; $display("[TB] FAIL rnd_fairness port=%0d: waited %0d want < %0d", g, waitc[g], NP); end
        last = g;
        if (pw[g]) shadow[pa[g][5:2]] = pd[g];
        else q.push_back('{cyc + 2, g, shadow[pa[g][5:2]]});
        pend[g] = 1'b0;
      end
      if (!ext_now) begin
        for (int p = 0; p < NP; p++) if (pend[p]) waitc[p]++;
      end
      tick();
    end
    checks++;
    if (q.size() !== 0) begin failures++; $display("[TB] FAIL rnd_returns_outstanding: got %0d want 0", q.size()); end
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    $display("[TB] shared_ram_arbiter bench start");
    test_reset();
    test_single_load();
    test_round_robin();
    test_store_then_load();
    test_host_path();
    test_reset_mid_flight();
    test_rotation_continue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_ram_arbiter.md
Name: shared_ram_arbiter

Overview:
- Shares one single-port BlockRam (data RAM, 1-cycle registered read) among NUM_PORTS shader-core load/store requesters, plus a host loader port.
- Round-robin arbitration with a req/grant handshake. RAM commands are registered, and read data returns with a per-port valid strobe.
- Sits between the per-core load/store state machines and the shared dataRam; replaces direct core-to-RAM wiring when several cores run.

Parameters:
- NUM_PORTS, 4, number of core requester ports (1..8)
- ADDRESS_WIDTH, 16, byte address width; RAM is word addressed with address[ADDRESS_WIDTH-1:2]
- WORD_WIDTH, 32, data word width

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- req  input  NUM_PORTS  per-port request; held with its fields until granted
- req_write  input  NUM_PORTS  1=store, 0=load, per port
- req_address  input  NUM_PORTS*ADDRESS_WIDTH  byte addresses; port i at slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- req_write_data  input  NUM_PORTS*WORD_WIDTH  store data, sliced likewise
- grant  output  NUM_PORTS  one-hot or zero; port i accepted at this clock edge
- read_valid  output  NUM_PORTS  one-hot or zero; read_data belongs to port i this cycle
- read_data  output  WORD_WIDTH  shared read return bus
- ext_enable  input  1  host owns the RAM (run low); core grants suppressed
- ext_write  input  1  host write strobe, effective only when ext_enable=1
- ext_address  input  ADDRESS_WIDTH  host byte address
- ext_write_data  input  WORD_WIDTH  host write data
- ram_address  output  ADDRESS_WIDTH-2  word address to BlockRam
- ram_write  output  1  BlockRam write enable
- ram_write_data  output  WORD_WIDTH  BlockRam write data
- ram_read_data  input  WORD_WIDTH  BlockRam read_data

Behaviour:
- Reset: while reset_n=0, grant=0, read_valid=0, ram_write=0, ram_address=0, ram_write_data=0, and both pipeline stages are cleared. Round-robin pointer last_grant=NUM_PORTS-1, so port 0 has top priority first.
- grant is combinational from req, ext_enable and last_grant.
  - grant[i]=1 for the first requesting port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - At most one grant per cycle.
  - grant=0 when ext_enable=1 or reset_n=0.
- Handshake: a requester sees grant[i]=1 in cycle T; the request is consumed at edge T. The requester may drop req or present a new request in T+1. A requester with req held continuously gets a grant at least once every NUM_PORTS cycles.
- On a grant at edge T:
  - last_grant <= i.
  - ram_address <= req_address_i[ADDRESS_WIDTH-1:2], ram_write <= req_write_i, ram_write_data <= req_write_data_i.
- Command stage 1, cycle T+1: RAM samples the command at edge T+1.
- Stage 2: for a granted read, read_valid[i]=1 during cycle T+2 only. read_data=ram_read_data (pass-through) in that cycle.
- Read latency is therefore 2 cycles from the grant cycle.
- Stores produce no read_valid.
- Read pipeline: two stages, each holding {valid, port index}. Fully pipelined; one request per cycle throughput.
- Idle cycle (no grant, ext_enable=0): ram_write <= 0; ram_address holds its value; the stage-1 valid bit clears.
- Host path, ext_enable=1:
  - ram_address <= ext_address[ADDRESS_WIDTH-1:2], ram_write <= ext_write, ram_write_data <= ext_write_data, registered the same way.
  - No core grants.
  - Reads already in the pipeline still complete and return read_valid on schedule.
- Simultaneous events: ext_enable rising in the same cycle as a core req means the host wins and the core is not granted. A store then a load to the same address on consecutive grants returns the new data (RAM write precedes the later read).
- Reset mid-operation: in-flight reads are dropped and no read_valid appears after reset release. The pointer returns to the reset value.
- read_data while read_valid=0 is don't-care.

Test Plan:
- Single port 2, load 0x0010 with RAM word 4 = 0xDEADBEEF → grant[2] in cycle T; ram_address=4, ram_write=0 in T+1; read_valid[2]=1 and read_data=0xDEADBEEF in T+2 only.
- All 4 ports hold req continuously from reset → grant order 0,1,2,3,0,1 on consecutive cycles; read_valid follows each grant by 2 cycles, one-hot each cycle.
- Port 1 stores 0x12345678 to 0x0020, port 3 then loads 0x0020 on the next grant → read_valid[3] with read_data=0x12345678.
- ext_enable=1 with ext_write to 0x0008, data 0xCAFEF00D, while ports 0 and 2 request → no grants; ram_address=2, ram_write=1. After ext_enable falls, port 0 is granted first, then port 2.
- Port 0 load granted; reset_n pulled low in T+1 for 1 cycle → read_valid stays 0 for 4 following cycles; after release, ports 0 and 3 both requesting → port 0 granted first.
- Port 2 requests alone for 3 cycles, then ports 1 and 3 join → rotation continues from last_grant=2, so port 3 is granted before port 1.
